// File: rtl/intdiv_pkg.sv
// Shared definitions for the intdiv datapath: signed-digit (SD2) codes, FSM states
// and the Booth recoding helpers used by the reconstructor.
package intdiv_pkg;

    localparam logic [1:0] SD2_ZERO   = 2'b00;
    localparam logic [1:0] SD2_POS1_1 = 2'b01;
    localparam logic [1:0] SD2_POS1_2 = 2'b10;
    localparam logic [1:0] SD2_NEG1   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic sd2_is_pos(input logic [1:0] d);
        return (d == SD2_POS1_1) || (d == SD2_POS1_2);
    endfunction

    function automatic logic sd2_is_neg(input logic [1:0] d);
        return d == SD2_NEG1;
    endfunction

    // Radix-2 Booth: {Q[0],q_m1} = 10 subtracts M, 01 adds M, 00/11 does nothing.
    function automatic logic [1:0] booth_sd2(input logic q0, input logic q_m1);
        logic [1:0] d;
        d = SD2_ZERO;
        if (q0 && !q_m1) begin
            d = SD2_NEG1;
        end else if (!q0 && q_m1) begin
            d = SD2_POS1_1;
        end
        return d;
    endfunction

endpackage

// File: rtl/intdiv_mulrec_step.sv
// One radix-2 Booth step: add/subtract M into A per the recoded digit, then
// arithmetic shift right of {A,Q,q_m1} by one bit.
module intdiv_mulrec_step
    import intdiv_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N:0]   i_a,
    input  logic [N:0]   i_m,
    input  logic [N-1:0] i_q,
    input  logic         i_q_m1,
    output logic [N:0]   o_a,
    output logic [N-1:0] o_q,
    output logic         o_q_m1
);

    logic [1:0] w_digit;
    logic [N:0] w_sum;

    always_comb begin
        w_digit = booth_sd2(i_q[0], i_q_m1);
        if (sd2_is_neg(w_digit)) begin
            w_sum = i_a - i_m;
        end else if (sd2_is_pos(w_digit)) begin
            w_sum = i_a + i_m;
        end else begin
            w_sum = i_a;
        end
        o_a    = {w_sum[N], w_sum[N:1]};
        o_q    = {w_sum[0], i_q[N-1:1]};
        o_q_m1 = i_q[0];
    end

endmodule

// File: rtl/intdiv_mulrec.sv
// Sequential reconstructor x = z*y + r (inverse of the intdiv divider): radix-2 Booth,
// one step per clock, then a single fix-up add of the remainder.
module intdiv_mulrec
    import intdiv_pkg::*;
#(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   z,
    input  logic [N-1:0]   y,
    input  logic [N-1:0]   r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] x,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [N:0]     r_a;
    logic [N:0]     r_m;
    logic [N-1:0]   r_q;
    logic           r_q_m1;
    logic [N-1:0]   r_r;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_x;

    logic [N:0]     w_step_a;
    logic [N-1:0]   w_step_q;
    logic           w_step_q_m1;
    logic           w_accept;
    logic           w_last;
    logic [2*N-1:0] w_fix_x;

    intdiv_mulrec_step #(.N(N)) u_step (
        .i_a    (r_a),
        .i_m    (r_m),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .o_a    (w_step_a),
        .o_q    (w_step_q),
        .o_q_m1 (w_step_q_m1)
    );

    assign w_last = (r_cnt == CW'(N - 1));

    // The product fits 2N bits, so A's top bit is redundant sign and drops out of the cast.
    assign w_fix_x = (2*N)'({r_a, r_q} + {{(N+1){r_r[N-1]}}, r_r});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_m    <= '0;
            r_q    <= '0;
            r_q_m1 <= 1'b0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_x    <= '0;
        end else if (w_accept) begin
            r_a    <= '0;
            r_m    <= {y[N-1], y};
            r_q    <= z;
            r_q_m1 <= 1'b0;
            r_r    <= r;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_a    <= w_step_a;
            r_q    <= w_step_q;
            r_q_m1 <= w_step_q_m1;
            r_cnt  <= r_cnt + CW'(1);
        end else if (r_state == FIX) begin
            r_x    <= w_fix_x;
        end
    end

    assign x = r_x;

endmodule

// File: tb/tb_intdiv_mulrec.sv
// Self-checking bench for intdiv_mulrec (N=5 and N=8 instances) against x = z*y + r.
module tb_intdiv_mulrec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid5, in_ready5, out_valid5, out_ready5, busy5;
    logic [4:0] z5, y5, r5;
    logic [9:0] x5;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  z8, y8, r8;
    logic [15:0] x8;

    int n_cmp = 0;
    int n_err = 0;

    intdiv_mulrec #(.N(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .z         (z5),
        .y         (y5),
        .r         (r5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .x         (x5),
        .busy      (busy5)
    );

    intdiv_mulrec #(.N(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .z         (z8),
        .y         (y8),
        .r         (r8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .x         (x8),
        .busy      (busy8)
    );

    // Directed cases with hand-computed results.
    int dz[5] = '{2, -3, 3, -16, -16};
    int dy[5] = '{3, 3, -3, -16, 15};
    int dr[5] = '{1, 0, -1, 15, -16};
    int dx[5] = '{7, -9, -10, 271, -256};

    task automatic start5(input int zi, input int yi, input int ri, output bit to);
        int c = 0;
        to = 1'b0;
        while (in_ready5 !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (in_ready5 !== 1'b1) begin
            to = 1'b1;
            return;
        end
        z5 = zi[4:0];
        y5 = yi[4:0];
        r5 = ri[4:0];
        in_valid5 = 1'b1;
        @(negedge clk);
        in_valid5 = 1'b0;
        z5 = 5'($urandom);
        y5 = 5'($urandom);
        r5 = 5'($urandom);
    endtask

    task automatic wait_valid5(output int lat, output bit to);
        lat = 0;
        while (out_valid5 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        to = (out_valid5 !== 1'b1);
    endtask

    task automatic take5();
        out_ready5 = 1'b1;
        @(negedge clk);
        out_ready5 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready5 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready5); end
        n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid5); end
        n_cmp++; if (busy5 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy5); end
        n_cmp++; if (x5 !== 10'd0) begin n_err++; $display("FAIL reset_x: got %h expected 000", x5); end
        n_cmp++; if (in_ready8 !== 1'b1 || x8 !== 16'd0) begin n_err++; $display("FAIL reset_n8: got in_ready=%b x=%h expected 1/0000", in_ready8, x8); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        bit to;
        int lat;
        for (int i = 0; i < 5; i++) begin
            start5(dz[i], dy[i], dr[i], to);
            if (!to) wait_valid5(lat, to);
            n_cmp++;
            if (to) begin
                n_err++;
                $display("FAIL directed_timeout[%0d]: got no handshake expected out_valid", i);
                continue;
            end
            n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL directed_latency[%0d]: got %0d expected 6", i, lat); end
            n_cmp++; if (int'($signed(x5)) !== dx[i]) begin n_err++; $display("FAIL directed_x[%0d]: got %0d expected %0d", i, $signed(x5), dx[i]); end
            take5();
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int lat;
        logic [9:0] xs;
        start5(7, -5, 3, to);
        if (!to) wait_valid5(lat, to);
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL bp_timeout: got no out_valid expected out_valid");
            return;
        end
        xs = x5;
        n_cmp++; if (int'($signed(xs)) !== -32) begin n_err++; $display("FAIL bp_x: got %0d expected -32", $signed(xs)); end
        for (int k = 0; k < 3; k++) begin
            in_valid5 = 1'b1;
            z5 = 5'($urandom);
            @(negedge clk);
            n_cmp++; if (out_valid5 !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, out_valid5); end
            n_cmp++; if (x5 !== xs) begin n_err++; $display("FAIL bp_hold_x[%0d]: got %h expected %h", k, x5, xs); end
            n_cmp++; if (in_ready5 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready5); end
        end
        in_valid5 = 1'b0;
        take5();
        n_cmp++; if (in_ready5 !== 1'b1 || busy5 !== 1'b0) begin n_err++; $display("FAIL bp_after_take: got in_ready=%b busy=%b expected 1/0", in_ready5, busy5); end
        n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL bp_after_valid: got %b expected 0", out_valid5); end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int res[$];
        z5 = 5'd4; y5 = 5'b11001; r5 = 5'd2;
        in_valid5 = 1'b1;
        out_ready5 = 1'b1;
        for (int c = 0; c < 60 && res.size() < 2; c++) begin
            if (in_ready5 === 1'b1) acc.push_back(c);
            if (out_valid5 === 1'b1) res.push_back(int'($signed(x5)));
            @(negedge clk);
            if (acc.size() == 1) begin
                z5 = 5'b11011; y5 = 5'd6; r5 = 5'b11111;
            end
        end
        in_valid5 = 1'b0;
        out_ready5 = 1'b0;
        n_cmp++;
        if (acc.size() < 2 || res.size() < 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d accepts %0d results expected 2/2", acc.size(), res.size());
            return;
        end
        n_cmp++; if (acc[1] - acc[0] !== 8) begin n_err++; $display("FAIL b2b_interval: got %0d expected 8", acc[1] - acc[0]); end
        n_cmp++; if (res[0] !== -26) begin n_err++; $display("FAIL b2b_x0: got %0d expected -26", res[0]); end
        n_cmp++; if (res[1] !== -31) begin n_err++; $display("FAIL b2b_x1: got %0d expected -31", res[1]); end
    endtask

    task automatic test_reset_midrun();
        bit to;
        int lat;
        int seen = 0;
        start5(5, 5, 5, to);
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL midrst_start: got no accept expected accept");
            return;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (in_ready5 !== 1'b1 || busy5 !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got in_ready=%b busy=%b expected 1/0", in_ready5, busy5); end
        n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid5); end
        n_cmp++; if (x5 !== 10'd0) begin n_err++; $display("FAIL midrst_x: got %h expected 000", x5); end
        out_ready5 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid5 === 1'b1) seen++;
        end
        out_ready5 = 1'b0;
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_result: got %0d valid cycles expected 0", seen); end
        start5(-7, 6, 2, to);
        if (!to) wait_valid5(lat, to);
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL midrst_recover_timeout: got no out_valid expected out_valid");
            return;
        end
        n_cmp++; if (int'($signed(x5)) !== -40) begin n_err++; $display("FAIL midrst_recover_x: got %0d expected -40", $signed(x5)); end
        take5();
    endtask

    task automatic test_sweep_n5();
        bit to;
        int lat;
        int ri;
        int expv;
        for (int zi = -16; zi < 16; zi++) begin
            for (int yi = -16; yi < 16; yi++) begin
                ri = int'($urandom_range(0, 31)) - 16;
                expv = zi * yi + ri;
                start5(zi, yi, ri, to);
                if (!to) wait_valid5(lat, to);
                n_cmp++;
                if (to) begin
                    n_err++;
                    $display("FAIL sweep5_timeout: z=%0d y=%0d r=%0d got no result expected %0d", zi, yi, ri, expv);
                    continue;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (int'($signed(x5)) !== expv) begin
                    n_err++;
                    $display("FAIL sweep5_x: z=%0d y=%0d r=%0d got %0d expected %0d", zi, yi, ri, $signed(x5), expv);
                end
                take5();
            end
        end
    endtask

    task automatic test_random_n8();
        int zi, yi, ri, expv, c;
        for (int i = 0; i < 2000; i++) begin
            if (i == 0) begin
                zi = -128; yi = -128; ri = 127;
            end else if (i == 1) begin
                zi = -128; yi = 127; ri = -128;
            end else begin
                zi = int'($urandom_range(0, 255)) - 128;
                yi = int'($urandom_range(0, 255)) - 128;
                ri = int'($urandom_range(0, 255)) - 128;
            end
            expv = zi * yi + ri;
            c = 0;
            while (in_ready8 !== 1'b1 && c < 50) begin
                @(negedge clk);
                c++;
            end
            z8 = zi[7:0];
            y8 = yi[7:0];
            r8 = ri[7:0];
            in_valid8 = 1'b1;
            @(negedge clk);
            in_valid8 = 1'b0;
            c = 0;
            while (out_valid8 !== 1'b1 && c < 40) begin
                @(negedge clk);
                c++;
            end
            n_cmp++;
            if (out_valid8 !== 1'b1) begin
                n_err++;
                $display("FAIL rand8_timeout: z=%0d y=%0d r=%0d got no result expected %0d", zi, yi, ri, expv);
                continue;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (int'($signed(x8)) !== expv) begin
                n_err++;
                $display("FAIL rand8_x: z=%0d y=%0d r=%0d got %0d expected %0d", zi, yi, ri, $signed(x8), expv);
            end
            out_ready8 = 1'b1;
            @(negedge clk);
            out_ready8 = 1'b0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid5  = 1'b0;
        out_ready5 = 1'b0;
        z5 = '0; y5 = '0; r5 = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        z8 = '0; y8 = '0; r8 = '0;

        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_sweep_n5();
        test_random_n8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
